// File: rtl/uart_tx_fifo_if.sv
// Byte-wide valid/ready push interface between a producer and the buffered UART transmitter.
interface uart_tx_fifo_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO, baud divider and serializer, all on the system clock.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  uart_tx_fifo_if.slave                 bus,
  output logic                          UART_TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            ready_q;

  logic            push;
  logic            pop;
  logic            baud_last;
  logic            stop_end;
  logic            frame_next;
  logic [NW-1:0]   count_next;

  assign bus.ready = ready_q;

  assign push       = bus.valid && ready_q;
  assign baud_last  = (baud_cnt == CW'(DIV - 1));
  assign stop_end   = (state == STOP) && baud_last && (bit_idx == 3'(STOP_BITS - 1));
  // The serializer takes a byte when idle or on the very last cycle of the final stop bit.
  assign pop        = (fifo_count != '0) && ((state == IDLE) || stop_end);
  assign count_next = fifo_count + NW'(push) - NW'(pop);
  assign frame_next = pop || !((state == IDLE) || stop_end);

  // NOTE: the storage array has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_next;
      // Registered ready and busy track the next-state count so they always agree with fifo_count.
      ready_q    <= (count_next != NW'(FIFO_DEPTH));
      busy       <= frame_next || (count_next != '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      UART_TX  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          UART_TX  <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            UART_TX <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            UART_TX  <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              UART_TX <= 1'b1;
              state   <= STOP;
            end else begin
              // shift[0] is the bit on the line; shift[1] is the next one out.
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= shift[1];
              shift   <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'(STOP_BITS - 1)) begin
              bit_idx <= '0;
              if (pop) begin
                shift   <= mem[rd_ptr];
                UART_TX <= 1'b0;
                state   <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
